// File: rtl/icache_pkg.sv
// Shared types, default geometry and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam int DEF_ADDR_W         = 10;
  localparam int DEF_LINES          = 8;
  localparam int DEF_WORDS_PER_LINE = 4;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int tag_width(input int addr_w, input int lines, input int wpl);
    return addr_w - log2_ceil(lines) - log2_ceil(wpl) - 2;
  endfunction

  function automatic int blk_width(input int addr_w, input int wpl);
    return addr_w - log2_ceil(wpl) - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data line store: combinational read by index, synchronous line fill,
// valid bits cleared on reset (tags and data keep whatever they held).
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int TAG_W  = 3,
  parameter int LINE_W = 32 * DEF_WORDS_PER_LINE,
  localparam int IDX_W = log2_ceil(LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINE_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_line;
    end
  end

  // reset wins over a fill landing on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, a three-state
// miss FSM refilling whole lines from block memory, and a saturating miss counter.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int OFF_W = log2_ceil(WORDS_PER_LINE),
  localparam int IDX_W = log2_ceil(LINES),
  localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS_PER_LINE),
  localparam int BLK_W = blk_width(ADDR_W, WORDS_PER_LINE)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [31:0]                  PC,
  output logic [31:0]                  INSTRUCTION,
  output logic                         BUSYWAIT,
  output logic                         MEM_READ,
  output logic [BLK_W-1:0]             MEM_ADDRESS,
  input  logic [32*WORDS_PER_LINE-1:0] MEM_READDATA,
  input  logic                         MEM_BUSYWAIT,
  output logic [15:0]                  MISS_COUNT
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [BLK_W-1:0] pc_blk;
  logic             unused_pc;

  assign pc_off    = PC[OFF_W+1:2];
  assign pc_idx    = PC[OFF_W+IDX_W+1:OFF_W+2];
  assign pc_tag    = PC[ADDR_W-1:OFF_W+IDX_W+2];
  assign pc_blk    = PC[ADDR_W-1:OFF_W+2];
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

  logic                         rd_valid;
  logic [TAG_W-1:0]             rd_tag;
  logic [32*WORDS_PER_LINE-1:0] rd_line;
  logic                         hit;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] miss_addr_q, miss_addr_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;
  logic             fill_en;

  icache_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .LINE_W(32 * WORDS_PER_LINE)
  ) u_array (
    .clk     (CLK),
    .rst     (RESET),
    .rd_idx  (pc_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_en   (fill_en),
    .wr_idx  (miss_addr_q[IDX_W-1:0]),
    .wr_tag  (miss_addr_q[BLK_W-1:IDX_W]),
    .wr_line (MEM_READDATA)
  );

  assign hit = rd_valid && (rd_tag == pc_tag);

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    miss_cnt_d  = miss_cnt_q;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d     = FETCH;
          miss_addr_d = pc_blk;
          miss_cnt_d  = sat_inc(miss_cnt_q);
        end
      end
      FETCH: begin
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // the miss address is datapath only and needs no reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_cnt_q <= miss_cnt_d;
    end
    miss_addr_q <= miss_addr_d;
  end

  assign BUSYWAIT    = !RESET && ((state_q != IDLE) || !hit);
  assign MEM_READ    = !RESET && (state_q == FETCH);
  assign MEM_ADDRESS = MEM_READ ? miss_addr_q : '0;
  assign INSTRUCTION = RESET ? 32'd0 : rd_line[{pc_off, 5'b00000} +: 32];
  assign MISS_COUNT  = miss_cnt_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: randomized fetch streams against a
// line-level reference model of the cache contents and a latency-programmable memory.
module tb_instruction_cache;

  localparam int ADDR_W = 10;
  localparam int LINES  = 8;
  localparam int WPL    = 4;
  localparam int BLK_W  = 6;

  logic                 CLK;
  logic                 RESET;
  logic [31:0]          PC;
  logic [31:0]          INSTRUCTION;
  logic                 BUSYWAIT;
  logic                 MEM_READ;
  logic [BLK_W-1:0]     MEM_ADDRESS;
  logic [32*WPL-1:0]    MEM_READDATA;
  logic                 MEM_BUSYWAIT;
  logic [15:0]          MISS_COUNT;

  instruction_cache #(
    .ADDR_W(ADDR_W), .LINES(LINES), .WORDS_PER_LINE(WPL)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MISS_COUNT(MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: a fixed pseudo-random word per (block, word) pair.
  function automatic logic [31:0] mem_word(input int blk, input int k);
    return (32'(blk) * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A000000;
  endfunction

  function automatic logic [32*WPL-1:0] line_of(input logic [BLK_W-1:0] blk, input logic busy);
    logic [32*WPL-1:0] l;
    l = '0;
    for (int k = 0; k < WPL; k++) l[32*k +: 32] = mem_word(int'(blk), k);
    return busy ? ~l : l;
  endfunction

  assign MEM_READDATA = line_of(MEM_ADDRESS, MEM_BUSYWAIT);

  // Memory holds busy for mem_lat cycles after MEM_READ rises, then releases.
  int mem_lat = 0;
  int fetch_cyc = 0;
  initial begin
    MEM_BUSYWAIT = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_READ) begin
        MEM_BUSYWAIT = (fetch_cyc < mem_lat);
        fetch_cyc++;
      end else begin
        fetch_cyc = 0;
        MEM_BUSYWAIT = (mem_lat != 0);
      end
    end
  end

  // Reference model: which memory block each line currently holds.
  bit ref_valid [LINES];
  int ref_blk   [LINES];
  int ref_miss  = 0;

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    ref_miss = 0;
  endtask

  task automatic model_step(input logic [31:0] pc, input int n,
                            output int stall, output bit miss, output int blk);
    int a, idx;
    a   = int'(pc % 32'(1 << ADDR_W));
    blk = a / (4 * WPL);
    idx = blk % LINES;
    miss = !(ref_valid[idx] && ref_blk[idx] == blk);
    if (miss) begin
      ref_valid[idx] = 1;
      ref_blk[idx]   = blk;
      if (ref_miss < 65535) ref_miss++;
      stall = n + 3;
    end else begin
      stall = 0;
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          stall;
    int          n_fetch;
    int          blk0;
    int          blk1;
    int          misscnt;
  } exp_t;

  exp_t exp_q[$];
  int   done_cnt = 0;

  // Monitor: accumulate stall cycles and refill addresses, compare when the stall ends.
  initial begin
    int   busy_cnt, nf, last_addr;
    int   seen [2];
    bit   prev_rd;
    exp_t e;
    busy_cnt = 0; nf = 0; prev_rd = 0; last_addr = 0;
    seen[0] = -1; seen[1] = -1;
    forever begin
      @(negedge CLK);
      if (!RESET && exp_q.size() > 0) begin
        if (BUSYWAIT) begin
          busy_cnt++;
          if (MEM_READ && !prev_rd) begin
            if (nf < 2) seen[nf] = int'(MEM_ADDRESS);
            nf++;
            last_addr = int'(MEM_ADDRESS);
          end else if (MEM_READ && prev_rd) begin
            chk("mem_addr_stable", 32'(MEM_ADDRESS), 32'(last_addr));
          end
          prev_rd = MEM_READ;
        end else begin
          e = exp_q.pop_front();
          chk("instruction", INSTRUCTION, e.instr);
          chk("stall_cycles", 32'(busy_cnt), 32'(e.stall));
          chk("refill_count", 32'(nf), 32'(e.n_fetch));
          if (e.n_fetch >= 1) chk("mem_address_1", 32'(seen[0]), 32'(e.blk0));
          if (e.n_fetch >= 2) chk("mem_address_2", 32'(seen[1]), 32'(e.blk1));
          chk("miss_count", 32'(MISS_COUNT), 32'(e.misscnt));
          busy_cnt = 0; nf = 0; prev_rd = 0;
          seen[0] = -1; seen[1] = -1;
          done_cnt++;
        end
      end
    end
  end

  // Present a PC (optionally moving it to wpc one cycle later, mid-refill) and wait for completion.
  task automatic issue(input logic [31:0] pc, input int n, input bit wobble, input logic [31:0] wpc);
    exp_t e;
    int   s1, s2, b1, b2, target, final_a;
    bit   m1, m2;
    model_step(pc, n, s1, m1, b1);
    e.stall = s1; e.n_fetch = m1 ? 1 : 0; e.blk0 = b1; e.blk1 = 0;
    final_a = int'(pc % 32'(1 << ADDR_W));
    if (wobble) begin
      model_step(wpc, n, s2, m2, b2);
      e.stall += s2;
      if (m2) begin
        if (e.n_fetch == 0) e.blk0 = b2; else e.blk1 = b2;
        e.n_fetch++;
      end
      final_a = int'(wpc % 32'(1 << ADDR_W));
    end
    e.instr   = mem_word(final_a / (4 * WPL), (final_a / 4) % WPL);
    e.misscnt = ref_miss;
    target  = done_cnt + 1;
    mem_lat = n;
    exp_q.push_back(e);
    PC = pc;
    if (wobble) begin
      @(posedge CLK);
      #1;
      PC = wpc;
    end
    for (int c = 0; c < 500 && done_cnt < target; c++) @(posedge CLK);
    if (done_cnt < target) begin
      chk("completion_timeout", 32'(done_cnt), 32'(target));
      exp_q.delete();
      done_cnt = target;
    end
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_instruction", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    chk("rst_miss_count", 32'(MISS_COUNT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic reset_mid_fetch();
    mem_lat = 1;
    PC = 32'h000;
    @(posedge CLK);   // enter FETCH
    #1;
    @(posedge CLK);   // second FETCH cycle, memory drops busy now
    #2;
    RESET = 1'b1;
    #1;
    chk("midrst_mem_read", 32'(MEM_READ), 32'd0);
    chk("midrst_busywait", 32'(BUSYWAIT), 32'd0);
    chk("midrst_instruction", INSTRUCTION, 32'd0);
    @(posedge CLK);
    #1;
    chk("midrst_miss_count", 32'(MISS_COUNT), 32'd0);
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, r;
    int a;
    RESET = 1'b1;
    PC    = 32'h0;
    @(posedge CLK);
    #1;
    do_reset();

    // cold miss, spatial hits, conflict pair
    issue(32'h000, 4, 0, 0);
    issue(32'h004, 4, 0, 0);
    issue(32'h008, 4, 0, 0);
    issue(32'h00C, 4, 0, 0);
    issue(32'h080, 2, 0, 0);
    issue(32'h000, 1, 0, 0);

    // reset during refill must not fill the line
    do_reset();
    issue(32'h004, 0, 0, 0);
    do_reset();
    reset_mid_fetch();
    issue(32'h000, 2, 0, 0);

    // PC moves mid-refill
    do_reset();
    issue(32'h000, 3, 1, 32'h040);
    issue(32'h00C, 3, 0, 0);

    // randomized streams, upper PC bits garbage
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 63)) * 4;
      else                           a = int'($urandom_range(0, 255)) * 4;
      r  = $urandom();
      pc = (r & 32'hFFFFFC00) | 32'(a) | (r & 32'h3);
      issue(pc, (i < 120) ? int'($urandom_range(0, 5)) : 0, 0, 0);
    end

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
